// File: rtl/pm_arbiter.sv
`default_nettype none
// pm_arbiter: shares one synchronous program memory between a loader writer (L),
// a data reader (D) and an instruction fetcher (F), with a fetch starvation guard.
module pm_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_halt,
  input  logic          i_f_req,
  input  logic [AW-1:0] i_f_addr,
  output logic          o_f_gnt,
  output logic          o_f_rvalid,
  output logic [DW-1:0] o_f_rdata,
  input  logic          i_d_req,
  input  logic [AW-1:0] i_d_addr,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_d_rdata,
  input  logic          i_l_req,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic          o_l_gnt,
  output logic          o_pm_en,
  output logic          o_pm_we,
  output logic [AW-1:0] o_pm_addr,
  output logic [DW-1:0] o_pm_wdata,
  input  logic [DW-1:0] i_pm_rdata
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]    r_starve;
  logic          r_pm_en;
  logic          r_pm_we;
  logic [AW-1:0] r_pm_addr;
  logic [DW-1:0] r_pm_wdata;
  logic          r_s1_f;
  logic          r_s1_d;
  logic          r_f_rvalid;
  logic          r_d_rvalid;

  logic w_starved;
  logic w_f_gnt;
  logic w_d_gnt;
  logic w_l_gnt;
  logic w_any_gnt;

  assign w_starved = (r_starve == C_MAX_WAIT);

  // A starved fetch overrides the normal L > D > F order for one grant.
  always_comb begin
    w_f_gnt = 1'b0;
    w_d_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (i_reset_n && !i_halt) begin
      if (i_f_req && w_starved) begin
        w_f_gnt = 1'b1;
      end else if (i_l_req) begin
        w_l_gnt = 1'b1;
      end else if (i_d_req) begin
        w_d_gnt = 1'b1;
      end else if (i_f_req) begin
        w_f_gnt = 1'b1;
      end
    end
  end

  assign w_any_gnt = w_f_gnt | w_d_gnt | w_l_gnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_starve <= 4'd0;
    end else if (!i_halt) begin
      if (!i_f_req || w_f_gnt) begin
        r_starve <= 4'd0;
      end else if (r_starve != C_MAX_WAIT) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  // Command stage: address/wdata hold their last value on idle cycles.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pm_en    <= 1'b0;
      r_pm_we    <= 1'b0;
      r_pm_addr  <= '0;
      r_pm_wdata <= '0;
      r_s1_f     <= 1'b0;
      r_s1_d     <= 1'b0;
    end else begin
      r_pm_en <= w_any_gnt;
      r_pm_we <= w_l_gnt;
      r_s1_f  <= w_f_gnt;
      r_s1_d  <= w_d_gnt;
      if (w_l_gnt) begin
        r_pm_addr  <= i_l_addr;
        r_pm_wdata <= i_l_wdata;
      end else if (w_d_gnt) begin
        r_pm_addr <= i_d_addr;
      end else if (w_f_gnt) begin
        r_pm_addr <= i_f_addr;
      end
    end
  end

  // Return stage lines up with the memory's one-cycle read latency.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_f_rvalid <= r_s1_f;
      r_d_rvalid <= r_s1_d;
    end
  end

  assign o_f_gnt    = w_f_gnt;
  assign o_d_gnt    = w_d_gnt;
  assign o_l_gnt    = w_l_gnt;
  assign o_pm_en    = r_pm_en;
  assign o_pm_we    = r_pm_we;
  assign o_pm_addr  = r_pm_addr;
  assign o_pm_wdata = r_pm_wdata;
  assign o_f_rvalid = r_f_rvalid;
  assign o_d_rvalid = r_d_rvalid;
  assign o_f_rdata  = r_f_rvalid ? i_pm_rdata : '0;
  assign o_d_rdata  = r_d_rvalid ? i_pm_rdata : '0;

endmodule
`default_nettype wire

// File: doc/pm_arbiter.md
PM_ARBITER -- requirements
Module: pm_arbiter

Interface
REQ-001 Parameter AW, default 16, program-memory address width.
REQ-002 Parameter DW, default 16, program-memory data width.
REQ-003 Parameter MAX_WAIT, default 4, range 1..15; fetch starvation limit in cycles.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 i_halt  in  1  high: no new grants issued.
REQ-007 i_f_req, i_f_addr  in  1, AW  fetch read request and address.
REQ-008 o_f_gnt, o_f_rvalid, o_f_rdata  out  1, 1, DW  fetch grant, read-valid pulse, read data.
REQ-009 i_d_req, i_d_addr  in  1, AW  data-read (LPM) request and address.
REQ-010 o_d_gnt, o_d_rvalid, o_d_rdata  out  1, 1, DW  data-read grant, read-valid pulse, read data.
REQ-011 i_l_req, i_l_addr, i_l_wdata  in  1, AW, DW  loader write request, address, data.
REQ-012 o_l_gnt  out  1  loader write grant.
REQ-013 o_pm_en, o_pm_we, o_pm_addr, o_pm_wdata  out  1, 1, AW, DW  memory command to synchronous PM.
REQ-014 i_pm_rdata  in  DW  PM read data, valid the cycle after the command cycle.

Function
REQ-015 Grants SHALL be combinational from current requests and registered state; at most one of o_f_gnt/o_d_gnt/o_l_gnt high per cycle.
REQ-016 No grant SHALL be high while i_halt=1 or i_reset_n=0.
REQ-017 Priority SHALL be L > D > F, except when starve counter = MAX_WAIT, then F wins over L and D.
REQ-018 Starve counter (4 bits) SHALL increment each cycle with i_f_req=1 and o_f_gnt=0, saturate at MAX_WAIT, clear when o_f_gnt=1 or i_f_req=0.
REQ-019 i_halt=1 SHALL freeze the starve counter.
REQ-020 A requester SHALL hold req/addr/wdata stable until gnt; the access is accepted on the edge where gnt=1.
REQ-021 Cycle T grant -> cycle T+1: o_pm_en=1, o_pm_addr/o_pm_wdata registered from winner, o_pm_we=1 only for L.
REQ-022 Cycle without grant -> next cycle o_pm_en=0, o_pm_we=0; o_pm_addr/o_pm_wdata hold last values.
REQ-023 Read granted in cycle T -> o_x_rvalid=1 for exactly cycle T+2, o_x_rdata=i_pm_rdata in that cycle.
REQ-024 o_f_rdata/o_d_rdata SHALL be valid only while matching rvalid=1; value otherwise don't-care.
REQ-025 Back-to-back grants (one per cycle, any mix of requesters) SHALL be supported with no bubble; rvalid pulses follow grant order.
REQ-026 Write then read of same address in consecutive grants SHALL return the new data (PM write-first ordering is not needed: write lands one cycle earlier).
REQ-027 L writes SHALL produce no rvalid.
REQ-028 Simultaneous req drop and gnt in same cycle: no grant was issued if req=0; gnt requires req=1.

Reset
REQ-029 While i_reset_n=0: o_pm_en=0, o_pm_we=0, o_pm_addr=0, o_pm_wdata=0, all gnt=0, all rvalid=0, starve counter=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight reads; no rvalid after release for pre-reset grants.
REQ-031 First grant possible in the first cycle after i_reset_n rises.

Verification
REQ-032 F-only: i_f_req=1 addr 0x0010 cycle 0 -> o_f_gnt cycle 0, o_pm_en/addr=0x0010 cycle 1, o_f_rvalid with PM[0x0010] cycle 2.
REQ-033 F,D,L all requesting continuously, MAX_WAIT=4 -> L granted 4 cycles, F granted cycle 4, counter clears, L resumes cycle 5.
REQ-034 L writes 0xBEEF to 0x0020 cycle 0, D reads 0x0020 cycle 1 -> o_d_rvalid cycle 3 with o_d_rdata=0xBEEF.
REQ-035 i_halt=1 for 3 cycles with F,D requesting -> no gnt, o_pm_en=0, counter frozen; grants resume cycle after i_halt falls.
REQ-036 D granted cycle 0, i_reset_n low cycle 1 -> all outputs 0 immediately, no o_d_rvalid in cycle 2 or later.
REQ-037 Alternating F/D grants 8 consecutive cycles -> 8 rvalid pulses, correct port and data each, no gaps.
